// File: rtl/aximm_chk_pkg.sv
// Shared definitions for the AXI-MM protocol checker and its error logger:
// channel indices and the layout of a logged error record.
package aximm_chk_pkg;

   localparam int CH = 5;

   localparam int AW = 0;
   localparam int W  = 1;
   localparam int B  = 2;
   localparam int AR = 3;
   localparam int R  = 4;

   // Record = {PAD zero bits, error map, timestamp}; header is one byte wide.
   localparam int REC_HDR = 8;
   localparam int PAD     = REC_HDR - CH;
   localparam int TS_LSB  = 0;

   function automatic int map_lsb(input int tsw);
      return tsw;
   endfunction

   function automatic int rec_width(input int tsw);
      return tsw + REC_HDR;
   endfunction

endpackage

// File: rtl/aximm_err_fifo.sv
// Synchronous record FIFO with a registered AXI-Stream head (no fall-through);
// pointers carry one extra bit so full and empty are distinguishable.
module aximm_err_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic [WIDTH-1:0]           tdata,
   output logic                       tvalid,
   input  logic                       tready
);

   localparam int PW   = $clog2(DEPTH);
   localparam int PTRW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTRW-1:0]  wr_ptr;
   logic [PTRW-1:0]  rd_ptr;
   logic [PTRW-1:0]  wr_next;
   logic [PTRW-1:0]  rd_next;
   logic [WIDTH-1:0] head_next;
   logic             pop;
   logic             accept;

   assign pop     = tvalid & tready;
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign accept  = push & (~full | pop);
   assign wr_next = wr_ptr + PTRW'(accept);
   assign rd_next = rd_ptr + PTRW'(pop);

   // When the queue drains to just the incoming record, the head comes from din.
   always_comb begin
      head_next = '0;
      if (wr_next != rd_next) begin
         if (rd_next == wr_ptr) head_next = din;
         else                   head_next = mem[rd_next[PW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr[PW-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         tvalid <= 1'b0;
         tdata  <= '0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         tvalid <= (wr_next != rd_next);
         tdata  <= head_next;
      end
   end

endmodule

// File: rtl/aximm_error_logger.sv
// Turns single-cycle AXI-MM checker error pulses into sticky flags, saturating
// per-channel counters, a first-error snapshot and a timestamped record stream.
module aximm_error_logger
   import aximm_chk_pkg::*;
#(
   parameter int CW    = 16,
   parameter int TSW   = 32,
   parameter int DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [CH-1:0]        error_map,
   output logic [CH-1:0]        sticky_map,
   output logic                 any_error,
   output logic [CH*CW-1:0]     err_count,
   output logic                 first_valid,
   output logic [CH-1:0]        first_map,
   output logic [TSW-1:0]       first_time,
   output logic                 overflow,
   output logic [CW-1:0]        dropped_count,
   output logic [TSW+7:0]       AXIS_TDATA,
   output logic                 AXIS_TVALID,
   input  logic                 AXIS_TREADY
);

   localparam int CNTW = $clog2(DEPTH) + 1;

   logic [TSW-1:0]   ts;
   logic             ev;
   logic             drop;
   logic             fifo_full;
   logic [CNTW-1:0]  fifo_count;
   logic [TSW+7:0]   record;

   logic [CH-1:0]    sticky_base;
   logic             fv_base;
   logic [CH-1:0]    fm_base;
   logic [TSW-1:0]   ft_base;
   logic             ovf_base;
   logic [CW-1:0]    drp_base;

   assign ev     = |error_map;
   assign record = {{PAD{1'b0}}, error_map, ts};
   assign drop   = ev & fifo_full & ~(AXIS_TVALID & AXIS_TREADY);

   // A clear coinciding with an event applies the event on top of zeroed state.
   assign sticky_base = clear ? '0   : sticky_map;
   assign fv_base     = clear ? 1'b0 : first_valid;
   assign fm_base     = clear ? '0   : first_map;
   assign ft_base     = clear ? '0   : first_time;
   assign ovf_base    = clear ? 1'b0 : overflow;
   assign drp_base    = clear ? '0   : dropped_count;

   assign any_error = |sticky_map;

   always_ff @(posedge clk) begin
      if (reset) begin
         ts            <= '0;
         sticky_map    <= '0;
         first_valid   <= 1'b0;
         first_map     <= '0;
         first_time    <= '0;
         overflow      <= 1'b0;
         dropped_count <= '0;
      end else begin
         ts         <= ts + TSW'(1);
         sticky_map <= sticky_base | error_map;
         if (ev && !fv_base) begin
            first_valid <= 1'b1;
            first_map   <= error_map;
            first_time  <= ts;
         end else begin
            first_valid <= fv_base;
            first_map   <= fm_base;
            first_time  <= ft_base;
         end
         overflow <= ovf_base | drop;
         if (drop && (drp_base != '1)) dropped_count <= drp_base + CW'(1);
         else                          dropped_count <= drp_base;
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_cnt
      logic [CW-1:0] cnt;
      logic [CW-1:0] base;

      assign base = clear ? '0 : cnt;
      assign err_count[i*CW +: CW] = cnt;

      always_ff @(posedge clk) begin
         if (reset)                             cnt <= '0;
         else if (error_map[i] && base != '1)   cnt <= base + CW'(1);
         else                                   cnt <= base;
      end
   end

   aximm_err_fifo #(
      .WIDTH (TSW + REC_HDR),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (ev),
      .din    (record),
      .full   (fifo_full),
      .count  (fifo_count),
      .tdata  (AXIS_TDATA),
      .tvalid (AXIS_TVALID),
      .tready (AXIS_TREADY)
   );

   always_comb begin
      assert (fifo_full == (fifo_count == CNTW'(DEPTH)));
   end

endmodule

// File: tb/tb_aximm_error_logger.sv
// Randomised bench for aximm_error_logger: a cycle-level reference model
// predicts diagnostics and queues expected records for a handshake monitor.
module tb_aximm_error_logger;
   import aximm_chk_pkg::*;

   localparam int CW    = 4;
   localparam int TSW   = 8;
   localparam int DEPTH = 16;
   localparam int DW    = TSW + 8;
   localparam int CMAX  = (1 << CW) - 1;
   localparam int TSMOD = 1 << TSW;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              clear = 1'b0;
   logic [CH-1:0]     error_map = '0;
   logic [CH-1:0]     sticky_map;
   logic              any_error;
   logic [CH*CW-1:0]  err_count;
   logic              first_valid;
   logic [CH-1:0]     first_map;
   logic [TSW-1:0]    first_time;
   logic              overflow;
   logic [CW-1:0]     dropped_count;
   logic [DW-1:0]     AXIS_TDATA;
   logic              AXIS_TVALID;
   logic              AXIS_TREADY = 1'b0;

   always #5 clk = ~clk;

   aximm_error_logger #(.CW(CW), .TSW(TSW), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .clear         (clear),
      .error_map     (error_map),
      .sticky_map    (sticky_map),
      .any_error     (any_error),
      .err_count     (err_count),
      .first_valid   (first_valid),
      .first_map     (first_map),
      .first_time    (first_time),
      .overflow      (overflow),
      .dropped_count (dropped_count),
      .AXIS_TDATA    (AXIS_TDATA),
      .AXIS_TVALID   (AXIS_TVALID),
      .AXIS_TREADY   (AXIS_TREADY)
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   int            m_ts;
   int            m_cnt [CH];
   int            m_occ;
   int            m_drp;
   int            m_ftime;
   bit [CH-1:0]   m_sticky;
   bit [CH-1:0]   m_fmap;
   bit            m_fv;
   bit            m_ovf;
   logic [DW-1:0] sb [$];

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit c, input bit [CH-1:0] m, input bit rdy);
      bit pop;
      logic [DW-1:0] rec;
      if (r) begin
         m_ts = 0; m_occ = 0; m_drp = 0; m_ftime = 0;
         m_sticky = '0; m_fmap = '0; m_fv = 0; m_ovf = 0;
         for (int i = 0; i < CH; i++) m_cnt[i] = 0;
         sb.delete();
         return;
      end
      pop = (m_occ > 0) && rdy;
      if (c) begin
         m_sticky = '0; m_fmap = '0; m_fv = 0; m_ftime = 0; m_ovf = 0; m_drp = 0;
         for (int i = 0; i < CH; i++) m_cnt[i] = 0;
      end
      if (m != 0) begin
         m_sticky |= m;
         for (int i = 0; i < CH; i++)
            if (m[i] && m_cnt[i] < CMAX) m_cnt[i]++;
         if (!m_fv) begin
            m_fv = 1; m_fmap = m; m_ftime = m_ts;
         end
         if (m_occ < DEPTH || pop) begin
            rec = '0;
            rec[TSW-1:0] = m_ts[TSW-1:0];
            rec[TSW +: CH] = m;
            sb.push_back(rec);
            m_occ++;
         end else begin
            m_ovf = 1;
            if (m_drp < CMAX) m_drp++;
         end
      end
      if (pop) m_occ--;
      m_ts = (m_ts + 1) % TSMOD;
   endtask

   task automatic check_diag();
      chk("sticky_map", sticky_map, m_sticky);
      chk("any_error", any_error, m_sticky != 0);
      for (int i = 0; i < CH; i++)
         chk($sformatf("err_count[%0d]", i), err_count[i*CW +: CW], m_cnt[i]);
      chk("first_valid", first_valid, m_fv);
      chk("first_map", first_map, m_fmap);
      chk("first_time", first_time, m_ftime);
      chk("overflow", overflow, m_ovf);
      chk("dropped_count", dropped_count, m_drp);
      chk("tvalid", AXIS_TVALID, m_occ > 0);
   endtask

   task automatic cycle(input bit r, input bit c, input bit [CH-1:0] m, input bit rdy);
      reset = r; clear = c; error_map = m; AXIS_TREADY = rdy;
      model_edge(r, c, m, rdy);
      @(posedge clk);
      #1;
      check_diag();
   endtask

   function automatic bit [CH-1:0] rnd_map();
      return CH'($urandom_range(1, (1 << CH) - 1));
   endfunction

   // monitor: sampled mid-cycle, inputs for the coming edge are already stable
   logic [DW-1:0] held;
   bit            hold = 0;
   int            n_rx = 0;

   always @(negedge clk) begin
      if (hold) begin
         chk("tvalid_held", AXIS_TVALID, 1);
         chk("tdata_held", AXIS_TDATA, held);
      end
      if (AXIS_TVALID && AXIS_TREADY && !reset) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL record_unexpected actual=%0h expected=none", AXIS_TDATA);
         end else begin
            chk("record", AXIS_TDATA, sb.pop_front());
            n_rx++;
         end
      end
      hold = AXIS_TVALID && !AXIS_TREADY && !reset;
      held = AXIS_TDATA;
   end

   initial begin
      bit [CH-1:0] m;

      repeat (3) cycle(1, 0, '0, 0);
      chk("reset_tdata", AXIS_TDATA, 0);

      // first event at timestamp 10
      repeat (10) cycle(0, 0, '0, 1);
      cycle(0, 0, 5'b00001, 0);
      chk("first_time_10", first_time, 10);
      chk("first_rec", AXIS_TDATA, {3'b000, 5'b00001, 8'd10});
      repeat (3) cycle(0, 0, '0, 1);

      // repeated multi-bit events under backpressure
      repeat (3) cycle(0, 0, 5'b10010, 0);
      cycle(0, 0, 5'b00100, 0);
      chk("cnt_W_3", err_count[W*CW +: CW], 3);
      chk("cnt_R_3", err_count[R*CW +: CW], 3);
      chk("cnt_B_1", err_count[B*CW +: CW], 1);
      repeat (3) cycle(0, 0, '0, 0);
      repeat (8) cycle(0, 0, '0, $urandom_range(0, 1));
      repeat (8) cycle(0, 0, '0, 1);

      // overflow: 20 events into a stalled queue, then full with a simultaneous pop
      for (int i = 0; i < 20; i++) cycle(0, 0, rnd_map(), 0);
      chk("dropped_4", dropped_count, 4);
      cycle(0, 0, rnd_map(), 1);
      chk("dropped_still_4", dropped_count, 4);
      repeat (20) cycle(0, 0, '0, 1);

      // clear coinciding with an event keeps queued records
      cycle(0, 1, '0, 1);
      repeat (7) cycle(0, 0, 5'b00010, 0);
      cycle(0, 1, 5'b00010, 0);
      chk("clear_cnt_W", err_count[W*CW +: CW], 1);
      repeat (2) cycle(0, 0, '0, 0);
      repeat (12) cycle(0, 0, '0, 1);

      // counter saturation
      repeat (20) cycle(0, 0, 5'b00001, 1);
      chk("sat_AW", err_count[AW*CW +: CW], CMAX);
      repeat (3) cycle(0, 0, '0, 1);

      // random traffic, long enough to wrap the timestamp
      for (int i = 0; i < 400; i++) begin
         m = $urandom_range(0, 1) ? rnd_map() : '0;
         cycle(0, $urandom_range(0, 99) < 3, m, $urandom_range(0, 3) != 0);
      end

      // reset with records still queued
      repeat (5) cycle(0, 0, rnd_map(), 0);
      cycle(1, 0, '0, 0);
      chk("midreset_tdata", AXIS_TDATA, 0);
      repeat (3) cycle(0, 0, '0, 1);

      repeat (20) cycle(0, 0, '0, 1);
      chk("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aximm_error_logger.md
Name: aximm_error_logger

Overview:
- Consumes the 5-bit per-channel error map produced by the AXI-MM protocol checker.
- Converts single-cycle error pulses into persistent diagnostic state: sticky flags, per-channel saturating counters, and a first-error snapshot with timestamp.
- Queues every error event as a timestamped record on an AXI-Stream output for a downstream reporter/UART.
- Sits directly downstream of the checker, same clock domain.

Parameters:
- CH, 5, number of error channels; bit order {R, AR, B, W, AW}, bit 0 = AW.
- CW, 16, width of each per-channel error counter and of the dropped-event counter.
- TSW, 32, width of the free-running timestamp.
- DEPTH, 16, event FIFO depth; power of 2, minimum 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  single-cycle pulse; clears diagnostic state
- error_map  in  CH  per-channel error pulses from the checker
- sticky_map  out  CH  OR-accumulated error bits since reset/clear
- any_error  out  1  (sticky_map != 0)
- err_count  out  CH*CW  counter for channel i at [i*CW +: CW]
- first_valid  out  1  a first-error snapshot is held
- first_map  out  CH  error_map of the first event
- first_time  out  TSW  timestamp of the first event
- overflow  out  1  sticky: at least one event dropped because the FIFO was full
- dropped_count  out  CW  number of dropped events, saturating
- AXIS_TDATA  out  TSW+8  record: {3'b0, error_map, timestamp}; timestamp in [TSW-1:0], map in [TSW+CH-1:TSW]
- AXIS_TVALID  out  1  record available
- AXIS_TREADY  in  1  downstream accepts record

Behaviour:
- **Reset (reset=1 at clk edge):** all outputs 0, timestamp 0, FIFO empty, AXIS_TVALID=0. Reset mid-stream discards queued records without completing them.
- **Timestamp:** free-running TSW-bit counter, +1 every cycle; wraps from all-ones to 0.
- **Event:** a cycle where error_map != 0. The event's timestamp is the counter value in that same cycle.
- **Latency:** all diagnostic outputs update on the edge following the sampled event (1 cycle).
- **sticky_map:** sticky_map <= sticky_map | error_map.
- **Counters:** channel i increments by 1 when error_map[i]=1; saturates at 2^CW-1 with no wrap. Several bits in one event each increment their own counter.
- **First snapshot:** captured only when first_valid=0; later events leave it untouched.
- **clear:**
  - Zeroes sticky_map, err_count, first_valid/first_map/first_time, overflow and dropped_count.
  - Does not affect the timestamp or the FIFO contents.
  - If an event coincides with clear, the event is applied on top of the cleared state: counter=1 per set bit, sticky_map=error_map, snapshot captured.
- **FIFO push:** each event pushes one record.
- **FIFO full:**
  - If the FIFO is full and no pop occurs that cycle, the record is dropped, overflow<=1 and dropped_count increments (saturating).
  - If full and a pop occurs in the same cycle, the push is accepted and occupancy is unchanged.
- **FIFO empty:** a push into an empty FIFO raises AXIS_TVALID on the next cycle (registered output, no combinational fall-through).
- **AXI-Stream rules:**
  - A pop occurs when AXIS_TVALID & AXIS_TREADY.
  - AXIS_TDATA is held stable while AXIS_TVALID=1 and AXIS_TREADY=0.
  - AXIS_TVALID never drops without a handshake.
  - Records leave in push order.
- **Throughput:** one push and one pop per cycle sustained.
- **FIFO pointers:** log2(DEPTH)+1 bits, so full and empty are distinguishable.

Decomposition:
- **Package aximm_chk_pkg:**
  - channel index constants: AW=0, W=1, B=2, AR=3, R=4
  - CH=5
  - record field offsets/widths (TS_LSB=0, MAP_LSB=TSW, PAD=8-CH)
  - Shared with the checker.
- **Sub-module aximm_err_fifo:** synchronous FIFO with registered AXI-Stream output and signals push, full, count. The logger instantiates one.

Test Plan:
- Reset release, then error_map=5'b00001 at timestamp 10:
  - 1 cycle later: sticky_map=00001, count[AW]=1, first_valid=1, first_map=00001, first_time=10.
  - One record {map=00001, ts=10} appears with TVALID=1.
- error_map=5'b10010 for 3 consecutive cycles, then 5'b00100:
  - count[W]=3, count[R]=3, count[B]=1.
  - first_map stays at the first event's map.
  - 4 records in order; TDATA stable under TREADY=0 backpressure.
- TREADY=0, 20 single-cycle events with DEPTH=16:
  - 16 records queued; overflow=1, dropped_count=4.
  - Then TREADY=1 drains exactly 16 records in order with timestamps ascending.
- FIFO full with TREADY=1 and an event in the same cycle: push accepted, dropped_count unchanged, occupancy stays 16.
- clear coincident with event error_map=00010, prior count[W]=7:
  - Result: count[W]=1, sticky_map=00010, first snapshot re-captured with the current timestamp.
  - FIFO contents preserved.
- Counter saturation with CW=4: 20 AW events give count[AW]=15.
- Timestamp wrap with TSW=4: an event at cycle 17 after reset records ts=1.
